instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the instruction ROM and downstream of the core's branch logic. It owns the fetch PC and drives the ROM chip-enable, read-enable and address ports. It captures the ROM's combinational read data into a small prefetch FIFO and presents {PC, instruction} pairs to the decoder over a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetching at the new target.

## Interface
- RESET_PC, 32'h0, fetch address after reset
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- ROM_ORIGIN, 32'h0, ROM base; used only by the range check
- ROM_LENGTH, 32'h10000, ROM size in bytes; used only by the range check

Ports:
- iIF_CLK  in  1  clock, rising edge
- iIF_RSTn  in  1  asynchronous, active-low reset
- iIF_REDIRECT  in  1  flush and restart fetch at iIF_TARGET
- iIF_TARGET  in  32  redirect byte address
- oIF_ROM_CE  out  1  ROM chip enable
- oIF_ROM_RD  out  1  ROM read enable; always equal to oIF_ROM_CE
- oIF_ROM_ADDR  out  32  ROM byte address (fetch PC)
- iIF_ROM_DATA  in  32  ROM read data, combinational from address
- oIF_VALID  out  1  FIFO head holds an instruction
- iIF_READY  in  1  decoder accepts head this cycle
- oIF_INSTR  out  32  head instruction word
- oIF_PC  out  32  head instruction byte address
- oIF_FAULT  out  1  fetch halted on bad address (macro-dependent)

## Operation
- The state machine has three states: IDLE, RUN and FAULT.
  - IDLE: entered on reset. Moves to RUN on the first clock edge after iIF_RSTn deasserts.
  - RUN: normal fetching.
  - FAULT: reached only with the macro enabled.
- Fetch PC register fpc resets to RESET_PC. Its low two bits are always 00; they are forced to 00 when loaded.
- Issue condition: state==RUN, count<FIFO_DEPTH, and iIF_REDIRECT==0.
  - When issue is true, oIF_ROM_CE=oIF_ROM_RD=1.
  - oIF_ROM_ADDR=fpc at all times.
  - There is no same-cycle pop credit.
- On an issuing edge:
  - {fpc, iIF_ROM_DATA} is written at the FIFO write pointer.
  - The write pointer and count advance.
  - fpc is set to fpc+4, modulo 2^32.
- Pop: on an edge where oIF_VALID && iIF_READY, the read pointer advances and count decrements.
- Simultaneous push and pop leaves count unchanged. Both pointers wrap modulo FIFO_DEPTH.
- oIF_VALID = (count!=0). oIF_INSTR and oIF_PC are the head entry. Head contents are undefined while VALID=0.
- Redirect has the highest priority. On an edge with iIF_REDIRECT=1:
  - count and both pointers are set to 0, and any pop that edge is discarded.
  - fpc is set to {iIF_TARGET[31:2], 2'b00}.
  - The state returns to RUN, also from FAULT.
- Reset mid-operation: all state clears immediately (asynchronous); in-flight FIFO entries are lost.

## Timing
- Reset values: oIF_ROM_CE=0, oIF_ROM_RD=0, oIF_ROM_ADDR=RESET_PC, oIF_VALID=0, oIF_FAULT=0, count=0, state=IDLE.
- Reset release:
  - Edge E0 moves IDLE to RUN.
  - CE is high during the cycle after E0.
  - Edge E1 captures the instruction at RESET_PC; oIF_VALID=1 after E1.
- Throughput: 1 instruction/cycle with iIF_READY held high. Count settles at 1.
- Redirect latency:
  - The redirect is sampled at edge N; VALID=0 after N.
  - CE addresses the target in the cycle after N.
  - VALID=1 with oIF_PC=target after edge N+1.
- Full: with count==FIFO_DEPTH, CE=0 and fpc holds. Issue resumes in the cycle after the first pop.
- Empty with READY=1: no pop occurs and count stays 0.

## Configuration
- Macro: IF_ADDR_CHECK_EN.
- Defined:
  - While in RUN, if fpc<ROM_ORIGIN or fpc≥ROM_ORIGIN+ROM_LENGTH, issue is suppressed. The next edge enters FAULT.
  - A redirect whose iIF_TARGET[1:0]!=00 still loads fpc. The state enters FAULT instead of RUN.
  - In FAULT: oIF_FAULT=1 and CE=0. The FIFO keeps draining normally. Only a redirect or reset leaves FAULT.
- Undefined:
  - No FAULT state exists and oIF_FAULT is tied 0.
  - Out-of-range addresses are issued as normal; the ROM returns 0, which is enqueued.
  - Misaligned target bits are silently dropped.

## Test plan
- Reset release, RESET_PC=0, ROM word i = i, READY=1: VALID rises after the 2nd edge; PC/INSTR stream (0,0),(4,1),(8,2)… with one instruction per cycle and no gaps.
- Backpressure, READY=0 for 10 cycles, FIFO_DEPTH=4: count reaches 4 and CE=0 from then on; after READY=1, PCs continue 0,4,8,12,16 in order with no duplicate or skip.
- Redirect to 0x100 while the FIFO holds 3 entries and READY=1: VALID=0 for exactly one cycle, the next delivered PC is 0x100, and no old entry appears.
- Redirect asserted while the FIFO is full and READY=1 on the same edge: the pop is discarded, count=0, and the next PC is the target.
- With IF_ADDR_CHECK_EN, ROM_LENGTH=0x10, fetch running from 0: PCs 0..0xC are delivered, then oIF_FAULT=1 and CE=0; a redirect to 0x4 clears FAULT and 0x4 is delivered next.
- With IF_ADDR_CHECK_EN, redirect to 0x6: oIF_FAULT=1 after the edge and no fetch occurs; without the macro the same stimulus fetches from 0x4.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction ROM and buffers
// {PC, instruction} pairs in a small prefetch FIFO for the decoder.
//
// Optional feature macro: IF_ADDR_CHECK_EN
//   When defined, fetches outside [ROM_ORIGIN, ROM_ORIGIN+ROM_LENGTH) and misaligned
//   redirect targets halt fetching in a FAULT state until the next redirect or reset.
//   When undefined, there is no FAULT state and oIF_FAULT is tied low.
//
// Ports:
//   iIF_CLK       clock, rising edge
//   iIF_RSTn      asynchronous active-low reset
//   iIF_REDIRECT  flush FIFO and restart fetch at iIF_TARGET
//   iIF_TARGET    redirect byte address
//   oIF_ROM_CE    ROM chip enable (high on every issuing cycle)
//   oIF_ROM_RD    ROM read enable, identical to oIF_ROM_CE
//   oIF_ROM_ADDR  ROM byte address (current fetch PC)
//   iIF_ROM_DATA  ROM read data, combinational from oIF_ROM_ADDR
//   oIF_VALID     FIFO head holds an instruction
//   iIF_READY     decoder accepts the head this cycle
//   oIF_INSTR     head instruction word
//   oIF_PC        head instruction byte address
//   oIF_FAULT     fetch halted on a bad address
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] ROM_ORIGIN = 32'h0,
  parameter logic [31:0] ROM_LENGTH = 32'h10000
) (
  input  logic        iIF_CLK,
  input  logic        iIF_RSTn,
  input  logic        iIF_REDIRECT,
  input  logic [31:0] iIF_TARGET,
  output logic        oIF_ROM_CE,
  output logic        oIF_ROM_RD,
  output logic [31:0] oIF_ROM_ADDR,
  input  logic [31:0] iIF_ROM_DATA,
  output logic        oIF_VALID,
  input  logic        iIF_READY,
  output logic [31:0] oIF_INSTR,
  output logic [31:0] oIF_PC,
  output logic        oIF_FAULT
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

`ifdef IF_ADDR_CHECK_EN
  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;
`else
  typedef enum logic [0:0] {StIdle, StRun} state_e;
`endif

  state_e            state_q, state_d;
  logic [31:0]       fpc_q, fpc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;

  logic [31:0]       pc_mem    [FIFO_DEPTH];
  logic [31:0]       instr_mem [FIFO_DEPTH];

  logic              addr_ok;
  logic              issue;
  logic              pop;

`ifdef IF_ADDR_CHECK_EN
  // 33-bit end address so a window reaching 2^32 does not wrap.
  localparam logic [32:0] RomEnd = {1'b0, ROM_ORIGIN} + {1'b0, ROM_LENGTH};
  assign addr_ok = (fpc_q >= ROM_ORIGIN) && ({1'b0, fpc_q} < RomEnd);
`else
  assign addr_ok = 1'b1;
`endif

  // No same-cycle pop credit: a full FIFO stalls issue even if the head leaves this edge.
  assign issue = (state_q == StRun) && (cnt_q < DepthCnt) && !iIF_REDIRECT && addr_ok;
  assign pop   = (cnt_q != '0) && iIF_READY;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (iIF_REDIRECT) begin
      // Redirect wins over push and pop; low target bits are dropped.
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      fpc_d   = iIF_TARGET & 32'hFFFF_FFFC;
      state_d = StRun;
`ifdef IF_ADDR_CHECK_EN
      if (iIF_TARGET[1:0] != 2'b00) state_d = StFault;
`endif
    end else begin
      if (issue) begin
        wptr_d = wptr_q + 1'b1;
        fpc_d  = fpc_q + 32'd4;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      case ({issue, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
      unique case (state_q)
        StIdle:  state_d = StRun;
`ifdef IF_ADDR_CHECK_EN
        StRun:   if (!addr_ok) state_d = StFault;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge iIF_CLK or negedge iIF_RSTn) begin
    if (!iIF_RSTn) begin
      state_q <= StIdle;
      fpc_q   <= RESET_PC & 32'hFFFF_FFFC;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only observed while count says they are live.
  always_ff @(posedge iIF_CLK) begin
    if (issue) begin
      pc_mem[wptr_q]    <= fpc_q;
      instr_mem[wptr_q] <= iIF_ROM_DATA;
    end
  end

  assign oIF_ROM_CE   = issue;
  assign oIF_ROM_RD   = issue;
  assign oIF_ROM_ADDR = fpc_q;
  assign oIF_VALID    = (cnt_q != '0);
  assign oIF_PC       = pc_mem[rptr_q];
  assign oIF_INSTR    = instr_mem[rptr_q];
`ifdef IF_ADDR_CHECK_EN
  assign oIF_FAULT    = (state_q == StFault);
`else
  assign oIF_FAULT    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-level model of the fetch stage is
// compared against the DUT on every negative clock edge, and directed scenarios add
// hand-computed literal expectations.
module tb_instr_fetch_unit;

  localparam int unsigned Depth = 4;
`ifdef IF_ADDR_CHECK_EN
  localparam logic [31:0] RomLen = 32'h400;
`else
  localparam logic [31:0] RomLen = 32'h10000;
`endif

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] target;
  logic        rom_ce, rom_rd;
  logic [31:0] rom_addr, rom_data;
  logic        valid, ready;
  logic [31:0] instr, pc;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (Depth),
    .ROM_ORIGIN (32'h0),
    .ROM_LENGTH (RomLen)
  ) u_dut (
    .iIF_CLK      (clk),
    .iIF_RSTn     (rst_n),
    .iIF_REDIRECT (redirect),
    .iIF_TARGET   (target),
    .oIF_ROM_CE   (rom_ce),
    .oIF_ROM_RD   (rom_rd),
    .oIF_ROM_ADDR (rom_addr),
    .iIF_ROM_DATA (rom_data),
    .oIF_VALID    (valid),
    .iIF_READY    (ready),
    .oIF_INSTR    (instr),
    .oIF_PC       (pc),
    .oIF_FAULT    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: word i holds i; outside the ROM it reads 0.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a < RomLen) ? (a >> 2) : 32'h0;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
`ifdef IF_ADDR_CHECK_EN
    return a < RomLen;
`else
    return 1'b1;
`endif
  endfunction

  assign rom_data = rom(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MIdle = 0, MRun = 1, MFault = 2;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  logic [31:0] m_fpc;
  int          m_state;
  logic [31:0] got[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pc.delete();
      q_ins.delete();
      m_fpc   = 32'h0;
      m_state = MIdle;
    end else if (redirect) begin
      q_pc.delete();
      q_ins.delete();
      m_fpc   = {target[31:2], 2'b00};
      m_state = MRun;
`ifdef IF_ADDR_CHECK_EN
      if (target[1:0] != 2'b00) m_state = MFault;
`endif
    end else begin
      bit iss, pp, ok;
      ok  = in_range(m_fpc);
      iss = (m_state == MRun) && (q_pc.size() < Depth) && ok;
      pp  = (q_pc.size() != 0) && ready;
      if (pp) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (iss) begin
        q_pc.push_back(m_fpc);
        q_ins.push_back(rom(m_fpc));
        m_fpc = m_fpc + 32'd4;
      end
      if (m_state == MIdle) m_state = MRun;
      else if (m_state == MRun && !ok) m_state = MFault;
    end
  end

  // Compare DUT against the model mid-cycle and log every delivered PC.
  always @(negedge clk) begin
    bit exp_ce;
    exp_ce = (m_state == MRun) && (q_pc.size() < Depth) && !redirect && in_range(m_fpc);
    chk("m_valid", {31'b0, valid}, {31'b0, q_pc.size() != 0});
    if (q_pc.size() != 0) begin
      chk("m_pc", pc, q_pc[0]);
      chk("m_instr", instr, q_ins[0]);
    end
    chk("m_ce", {31'b0, rom_ce}, {31'b0, exp_ce});
    chk("m_rd", {31'b0, rom_rd}, {31'b0, exp_ce});
    chk("m_addr", rom_addr, m_fpc);
    chk("m_fault", {31'b0, fault}, {31'b0, m_state == MFault});
    if (valid && ready && !redirect) got.push_back(pc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deliv(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) step();
    chk("deliv_bound", {31'b0, got.size() >= n}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect = 1'b1;
    target   = t;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    ready    = 1'b1;
    redirect = 1'b0;
    target   = 32'h0;
    step();
    step();
    chk("rst_ce", {31'b0, rom_ce}, 32'd0);
    chk("rst_rd", {31'b0, rom_rd}, 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);

    // Reset release and streaming with READY held high.
    rst_n = 1'b1;
    got.delete();
    step();
    chk("e0_valid", {31'b0, valid}, 32'd0);
    chk("e0_ce", {31'b0, rom_ce}, 32'd1);
    step();
    chk("e1_valid", {31'b0, valid}, 32'd1);
    chk("e1_pc", pc, 32'h0);
    chk("e1_instr", instr, 32'h0);
    repeat (6) step();
    chk("stream_count", got.size(), 32'd6);
    for (int k = 0; k < 6; k++) chk("stream_pc", got[k], 32'(4 * k));

    // Mid-operation reset, then backpressure until full.
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, valid}, 32'd0);
    step();
    rst_n = 1'b1;
    got.delete();
    repeat (10) step();
    chk("bp_ce", {31'b0, rom_ce}, 32'd0);
    chk("bp_valid", {31'b0, valid}, 32'd1);
    chk("bp_pc", pc, 32'h0);
    ready = 1'b1;
    wait_deliv(5, 20);
    for (int k = 0; k < 5; k++) chk("bp_order", got[k], 32'(4 * k));

    // Redirect while entries are buffered.
    got.delete();
    do_redirect(32'h100);
    chk("rd_valid0", {31'b0, valid}, 32'd0);
    chk("rd_addr", rom_addr, 32'h100);
    step();
    chk("rd_valid1", {31'b0, valid}, 32'd1);
    chk("rd_pc", pc, 32'h100);
    chk("rd_instr", instr, 32'h40);
    wait_deliv(3, 10);
    chk("rd_first", got[0], 32'h100);
    chk("rd_second", got[1], 32'h104);
    chk("rd_third", got[2], 32'h108);

    // Redirect on the same edge as a pop from a full FIFO.
    ready = 1'b0;
    repeat (6) step();
    chk("full_ce", {31'b0, rom_ce}, 32'd0);
    ready = 1'b1;
    do_redirect(32'h200);
    chk("fl_valid0", {31'b0, valid}, 32'd0);
    step();
    chk("fl_pc", pc, 32'h200);

    // Misaligned redirect target.
    do_redirect(32'h6);
`ifdef IF_ADDR_CHECK_EN
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_ce", {31'b0, rom_ce}, 32'd0);
    step();
    chk("mis_valid", {31'b0, valid}, 32'd0);
    chk("mis_fault2", {31'b0, fault}, 32'd1);

    // Run off the top of the ROM window.
    do_redirect(32'h3F0);
    got.delete();
    repeat (8) step();
    chk("rng_count", got.size(), 32'd4);
    for (int k = 0; k < 4; k++) chk("rng_pc", got[k], 32'(32'h3F0 + 4 * k));
    chk("rng_fault", {31'b0, fault}, 32'd1);
    chk("rng_ce", {31'b0, rom_ce}, 32'd0);
    do_redirect(32'h3F4);
    chk("rng_clear", {31'b0, fault}, 32'd0);
    step();
    chk("rng_pc_next", pc, 32'h3F4);
`else
    chk("mis_addr", rom_addr, 32'h4);
    chk("mis_fault", {31'b0, fault}, 32'd0);
    step();
    chk("mis_pc", pc, 32'h4);
    chk("mis_instr", instr, 32'h1);

    // Past the ROM end the data reads zero; the PC wraps modulo 2^32.
    do_redirect(32'hFFF8);
    step();
    chk("end_pc", pc, 32'hFFF8);
    chk("end_instr", instr, 32'h3FFE);
    repeat (3) step();
    do_redirect(32'hFFFF_FFF8);
    step();
    chk("wrap_pc0", pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", pc, 32'h0);
    chk("wrap_instr", instr, 32'h0);
`endif
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
